output_layer_sequencer: RTL

OUTPUT_LAYER_SEQUENCER -- requirements
Module: output_layer_sequencer

---
 rtl/mnist_pkg.sv | 16 +
 rtl/signed_argmax_acc.sv | 46 ++++
 rtl/output_layer_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST inference pipeline: sequencer state encoding
// and the default geometry of the output layer.
package mnist_pkg;

  localparam int N_NEURONS_DEF = 10;
  localparam int DATA_W_DEF    = 32;
  localparam int IDX_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } seq_state_e;

endpackage

// File: rtl/signed_argmax_acc.sv
// Running signed maximum tracker; keeps the index of the first occurrence of
// the largest value offered since the last clear.
module signed_argmax_acc
  import mnist_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [IDX_W-1:0]  max_idx_o
);

  logic signed [DATA_W-1:0] max_q;
  logic [IDX_W-1:0]         idx_q;
  logic                     have_q;
  logic                     take_s;

  // strict compare keeps the lowest index on ties
  assign take_s = en_i && (!have_q || ($signed(data_i) > max_q));

  // accumulator state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q  <= '0;
      idx_q  <= '0;
      have_q <= 1'b0;
    end else if (clr_i) begin
      max_q  <= '0;
      idx_q  <= '0;
      have_q <= 1'b0;
    end else if (take_s) begin
      max_q  <= $signed(data_i);
      idx_q  <= idx_i;
      have_q <= 1'b1;
    end else begin
      have_q <= have_q;
    end
  end

  assign max_idx_o = idx_q;

endmodule

// File: rtl/output_layer_sequencer.sv
// Launches all output neurons, gathers their results as they finish, streams
// them out over AXI4-Stream and reports the argmax of the streamed results.
module output_layer_sequencer
  import mnist_pkg::*;
#(
  parameter int N_NEURONS   = N_NEURONS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        start,
  output logic                        busy,
  output logic [N_NEURONS-1:0]        n_start,
  input  logic [N_NEURONS-1:0]        n_done,
  input  logic [N_NEURONS*DATA_W-1:0] n_result,
  output logic [DATA_W-1:0]           m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        m_tlast,
  output logic [IDX_W-1:0]            argmax,
  output logic                        argmax_valid,
  output logic                        err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam logic [N_NEURONS-1:0] MASK_FULL = {N_NEURONS{1'b1}};
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(N_NEURONS - 1);

  seq_state_e                  state_q, state_d;
  logic [N_NEURONS-1:0]        mask_q, mask_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        err_q, err_d;
  logic                        valid_q, valid_d;
  logic [N_NEURONS*DATA_W-1:0] buf_q;
  logic [N_NEURONS-1:0]        cap_s;
  logic [DATA_W-1:0]           tdata_s;
  logic                        xfer_s;
  logic                        acc_clr_s;

  assign cap_s   = (state_q == ST_WAIT) ? (n_done & ~mask_q) : '0;
  assign tdata_s = buf_q[int'(idx_q)*DATA_W +: DATA_W];
  assign xfer_s  = (state_q == ST_STREAM) && m_tready;

  // next-state and bookkeeping
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    valid_d   = valid_q;
    acc_clr_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_LAUNCH;
          mask_d    = '0;
          err_d     = 1'b0;
          valid_d   = 1'b0;
          acc_clr_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        mask_d = mask_q | cap_s;
        cnt_d  = cnt_q + CNT_W'(1);
        if (mask_q == MASK_FULL) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end else if ((cnt_d == CNT_W'(TIMEOUT_CYC)) && (mask_d != MASK_FULL)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_STREAM: begin
        if (m_tready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            valid_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // control registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  // result buffer, one word per neuron, written once per inference
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_q <= '0;
    end else begin
      for (int i = 0; i < N_NEURONS; i++) begin
        if (cap_s[i]) begin
          buf_q[i*DATA_W +: DATA_W] <= n_result[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  signed_argmax_acc #(
    .DATA_W(DATA_W)
  ) u_acc (
    .clk      (aclk),
    .rst_n    (aresetn),
    .clr_i    (acc_clr_s),
    .en_i     (xfer_s),
    .data_i   (tdata_s),
    .idx_i    (idx_q),
    .max_idx_o(argmax)
  );

  assign busy         = (state_q != ST_IDLE);
  assign n_start      = (state_q == ST_LAUNCH) ? MASK_FULL : '0;
  assign m_tvalid     = (state_q == ST_STREAM);
  assign m_tlast      = (state_q == ST_STREAM) && (idx_q == LAST_IDX);
  assign m_tdata      = (state_q == ST_STREAM) ? tdata_s : '0;
  assign argmax_valid = valid_q;
  assign err_timeout  = err_q;

endmodule
